// File: rtl/lvds_chk_pkg.sv
// Shared types and default geometry for the LVDS ramp capture/check slice.
// The checker state enum lives here so the top and the channel share one definition.
package lvds_chk_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_LANES    = 48;
    localparam int DEF_ERR_W    = 32;

endpackage

// File: rtl/ramp_chan_checker.sv
// One ADC channel: compares each captured sample against the previous one plus STEP,
// tracks ramp lock and keeps a saturating error count.
module ramp_chan_checker
    import lvds_chk_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int STEP     = 1,
    parameter int LOCK_CNT = 4,
    parameter int MISS_MAX = 8,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmp_en,
    input  logic [SAMPLE_W-1:0] cur_sample,
    input  logic [SAMPLE_W-1:0] prev_sample,
    input  logic                clr_cnt,
    output logic                locked,
    output logic [ERR_W-1:0]    err_cnt
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(MISS_MAX + 1);
    localparam logic [SAMPLE_W-1:0] STEP_V    = SAMPLE_W'(STEP);
    localparam logic [RUN_W-1:0]    RUN_LAST  = RUN_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0]   MISS_LAST = MISS_W'(MISS_MAX - 1);

    chk_state_t          state_q, state_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [SAMPLE_W-1:0] expect_v;
    logic                match;

    // Addition wraps naturally, so 0xFFFF -> 0x0000 counts as a match for STEP=1.
    assign expect_v = prev_sample + STEP_V;
    assign match    = (cur_sample == expect_v);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEARCH;
            run_q   <= '0;
            miss_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        miss_d  = miss_q;
        err_d   = err_q;
        if (cmp_en) begin
            case (state_q)
                SEARCH: begin
                    if (match) begin
                        if (run_q == RUN_LAST) begin
                            state_d = LOCKED;
                            run_d   = '0;
                            miss_d  = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        miss_d = '0;
                    end else begin
                        // The mismatch that drops lock is still counted.
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        if (miss_q == MISS_LAST) begin
                            state_d = SEARCH;
                            run_d   = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end
                end
            endcase
        end
        if (clr_cnt) begin
            err_d = '0;
        end
    end

    assign locked  = (state_q == LOCKED);
    assign err_cnt = err_q;

endmodule

// File: rtl/lvds_ramp_checker.sv
// Registers the LVDS lane bus, forwards it to the ILA probe and checks every
// SAMPLE_W-wide channel against the ADC ramp test pattern.
module lvds_ramp_checker
    import lvds_chk_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int NCH      = LANES / SAMPLE_W,
    parameter int STEP     = 1,
    parameter int LOCK_CNT = 4,
    parameter int MISS_MAX = 8,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LANES-1:0]     lrx_data,
    input  logic                 clr_cnt,
    output logic [LANES-1:0]     dout,
    output logic                 dout_vld,
    output logic [NCH-1:0]       locked,
    output logic [NCH*ERR_W-1:0] err_cnt
);

    if ((LANES % SAMPLE_W) != 0 || (NCH * SAMPLE_W) != LANES ||
        LOCK_CNT < 1 || MISS_MAX < 1) begin : g_bad_cfg
        $error("lvds_ramp_checker: invalid LANES/SAMPLE_W/LOCK_CNT/MISS_MAX configuration");
    end

    logic [LANES-1:0] cap_q;
    logic [LANES-1:0] prev_q;
    logic             vld_q;
    logic             prime_q;
    logic             cmp_en;

    // prime_q trails vld_q by one edge so the first compare sees two real samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q   <= '0;
            prev_q  <= '0;
            vld_q   <= 1'b0;
            prime_q <= 1'b0;
        end else begin
            cap_q   <= lrx_data;
            prev_q  <= cap_q;
            vld_q   <= 1'b1;
            prime_q <= vld_q;
        end
    end

    assign cmp_en   = prime_q & vld_q;
    assign dout     = cap_q;
    assign dout_vld = vld_q;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        ramp_chan_checker #(
            .SAMPLE_W (SAMPLE_W),
            .STEP     (STEP),
            .LOCK_CNT (LOCK_CNT),
            .MISS_MAX (MISS_MAX),
            .ERR_W    (ERR_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .cmp_en      (cmp_en),
            .cur_sample  (cap_q[c*SAMPLE_W +: SAMPLE_W]),
            .prev_sample (prev_q[c*SAMPLE_W +: SAMPLE_W]),
            .clr_cnt     (clr_cnt),
            .locked      (locked[c]),
            .err_cnt     (err_cnt[c*ERR_W +: ERR_W])
        );
    end

endmodule

// File: tb/tb_lvds_ramp_checker.sv
// Bench for lvds_ramp_checker: a reference model feeds a scoreboard every cycle,
// with a narrow-counter instance alongside to exercise saturation.
module tb_lvds_ramp_checker;
    import lvds_chk_pkg::*;

    localparam int LANES    = 48;
    localparam int SAMPLE_W = 16;
    localparam int NCH      = 3;
    localparam int ERR_W    = 32;
    localparam int SAT_W    = 4;
    localparam int STEP     = 1;
    localparam int LOCK_CNT = 4;
    localparam int MISS_MAX = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [LANES-1:0]     lrx_data = '0;
    logic                 clr_cnt = 1'b0;
    logic [LANES-1:0]     dout, dout_s;
    logic                 dout_vld, dout_vld_s;
    logic [NCH-1:0]       locked, locked_s;
    logic [NCH*ERR_W-1:0] err_cnt;
    logic [NCH*SAT_W-1:0] err_cnt_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lvds_ramp_checker dut (
        .clk(clk), .rst_n(rst_n), .lrx_data(lrx_data), .clr_cnt(clr_cnt),
        .dout(dout), .dout_vld(dout_vld), .locked(locked), .err_cnt(err_cnt)
    );

    lvds_ramp_checker #(.ERR_W(SAT_W)) dut_sat (
        .clk(clk), .rst_n(rst_n), .lrx_data(lrx_data), .clr_cnt(clr_cnt),
        .dout(dout_s), .dout_vld(dout_vld_s), .locked(locked_s), .err_cnt(err_cnt_s)
    );

    typedef struct {
        logic [LANES-1:0]     dout;
        logic                 vld;
        logic [NCH-1:0]       locked;
        logic [NCH*ERR_W-1:0] err;
        logic [NCH*SAT_W-1:0] err_s;
    } exp_t;

    typedef struct {
        logic [SAMPLE_W-1:0] s;
        logic                vld_exp;
        logic [NCH-1:0]      lock_exp;
    } lock_row_t;

    exp_t sb_q[$];

    chk_state_t       m_state[NCH];
    int               m_run[NCH];
    int               m_miss[NCH];
    longint           m_err[NCH];
    longint           m_err_s[NCH];
    int               m_ncap;
    logic [LANES-1:0] m_cap, m_prev;
    logic [SAMPLE_W-1:0] val[NCH];

    function automatic logic [LANES-1:0] pack3(input logic [SAMPLE_W-1:0] a, b, c);
        return {c, b, a};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        m_ncap = 0;
        m_cap  = '0;
        m_prev = '0;
        for (int c = 0; c < NCH; c++) begin
            m_state[c] = SEARCH;
            m_run[c]   = 0;
            m_miss[c]  = 0;
            m_err[c]   = 0;
            m_err_s[c] = 0;
        end
    endtask

    // Model of one clock edge: the compare uses the two samples already held.
    task automatic modelEdge(input logic [LANES-1:0] sample, input logic clr);
        logic [SAMPLE_W-1:0] diff;
        if (m_ncap >= 2) begin
            for (int c = 0; c < NCH; c++) begin
                diff = m_cap[c*SAMPLE_W +: SAMPLE_W] - m_prev[c*SAMPLE_W +: SAMPLE_W];
                if (m_state[c] == SEARCH) begin
                    if (diff == SAMPLE_W'(STEP)) begin
                        m_run[c]++;
                        if (m_run[c] == LOCK_CNT) begin
                            m_state[c] = LOCKED;
                            m_run[c]   = 0;
                            m_miss[c]  = 0;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end else begin
                    if (diff == SAMPLE_W'(STEP)) begin
                        m_miss[c] = 0;
                    end else begin
                        if (m_err[c] < 64'hFFFF_FFFF) m_err[c]++;
                        if (m_err_s[c] < 15) m_err_s[c]++;
                        m_miss[c]++;
                        if (m_miss[c] == MISS_MAX) begin
                            m_state[c] = SEARCH;
                            m_run[c]   = 0;
                            m_miss[c]  = 0;
                        end
                    end
                end
            end
        end
        if (clr) begin
            for (int c = 0; c < NCH; c++) begin
                m_err[c]   = 0;
                m_err_s[c] = 0;
            end
        end
        m_prev = m_cap;
        m_cap  = sample;
        if (m_ncap < 2) m_ncap++;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 128'd1, 128'd0);
            return;
        end
        e = sb_q.pop_front();
        check("dout", dout, e.dout);
        check("dout_vld", dout_vld, e.vld);
        check("locked", locked, e.locked);
        check("err_cnt", err_cnt, e.err);
        check("locked_sat", locked_s, e.locked);
        check("err_cnt_sat", err_cnt_s, e.err_s);
    endtask

    task automatic applyStimulus(input logic [LANES-1:0] sample, input logic clr);
        exp_t e;
        lrx_data = sample;
        clr_cnt  = clr;
        modelEdge(sample, clr);
        e.dout = sample;
        e.vld  = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            e.locked[c] = (m_state[c] == LOCKED);
            e.err[c*ERR_W +: ERR_W]   = ERR_W'(m_err[c]);
            e.err_s[c*SAT_W +: SAT_W] = SAT_W'(m_err_s[c]);
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
        clr_cnt = 1'b0;
    endtask

    task automatic cycleRamp(input int n, input logic clr);
        for (int i = 0; i < n; i++) begin
            applyStimulus(pack3(val[0], val[1], val[2]), clr);
            for (int c = 0; c < NCH; c++) val[c] = val[c] + 16'd1;
        end
    endtask

    task automatic zeroCh2(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(pack3(val[0], val[1], 16'h0000), 1'b0);
            val[0] = val[0] + 16'd1;
            val[1] = val[1] + 16'd1;
        end
    endtask

    function automatic logic [ERR_W-1:0] errOf(input int c);
        return err_cnt[c*ERR_W +: ERR_W];
    endfunction

    task automatic runLockTable();
        lock_row_t tbl[8];
        for (int k = 0; k < 8; k++) begin
            tbl[k].s        = SAMPLE_W'(k);
            tbl[k].vld_exp  = 1'b1;
            tbl[k].lock_exp = (k >= 5) ? 3'b111 : 3'b000;
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(pack3(tbl[k].s, tbl[k].s, tbl[k].s), 1'b0);
            check($sformatf("lock_tbl_vld_e%0d", k + 1), dout_vld, tbl[k].vld_exp);
            check($sformatf("lock_tbl_locked_e%0d", k + 1), locked, tbl[k].lock_exp);
        end
        for (int c = 0; c < NCH; c++) val[c] = 16'd8;
    endtask

    initial begin
        logic [LANES-1:0] smp;
        modelReset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dout", dout, '0);
        check("reset_vld", dout_vld, 1'b0);
        check("reset_locked", locked, '0);
        check("reset_err", err_cnt, '0);
        check("reset_err_sat", err_cnt_s, '0);

        @(negedge clk);
        rst_n = 1'b1;
        runLockTable();
        cycleRamp(92, 1'b0);
        check("lock100_err", err_cnt, '0);
        check("lock100_locked", locked, 3'b111);

        // Channel 0 jumps to just below the wrap; clear lands on the jump's mismatch.
        val[0] = 16'hFFF8;
        cycleRamp(1, 1'b0);
        cycleRamp(1, 1'b1);
        check("clr_on_err_ch0", errOf(0), '0);
        cycleRamp(12, 1'b0);
        check("wrap_locked0", locked[0], 1'b1);
        check("wrap_err0", errOf(0), '0);

        smp = pack3(val[0], 16'h1234, val[2]);
        applyStimulus(smp, 1'b0);
        for (int c = 0; c < NCH; c++) val[c] = val[c] + 16'd1;
        cycleRamp(3, 1'b0);
        check("glitch_err1", errOf(1), 32'd2);
        check("glitch_locked", locked, 3'b111);
        check("glitch_err0", errOf(0), '0);
        check("glitch_err2", errOf(2), '0);

        zeroCh2(12);
        check("loss_locked2", locked[2], 1'b0);
        check("loss_err2", errOf(2), 32'd8);
        check("loss_locked01", locked[1:0], 2'b11);
        val[2] = 16'd1;
        cycleRamp(4, 1'b0);
        check("relock_3match", locked[2], 1'b0);
        cycleRamp(1, 1'b0);
        check("relock_4match", locked[2], 1'b1);

        zeroCh2(12);
        check("sat_err2", err_cnt_s[2*SAT_W +: SAT_W], 4'hF);
        check("nosat_err2", errOf(2), 32'd16);
        val[2] = 16'd1;
        cycleRamp(6, 1'b0);
        smp = pack3(val[0], val[1], 16'hABCD);
        applyStimulus(smp, 1'b0);
        for (int c = 0; c < NCH; c++) val[c] = val[c] + 16'd1;
        cycleRamp(3, 1'b0);
        check("sat_hold", err_cnt_s[2*SAT_W +: SAT_W], 4'hF);
        check("nosat_18", errOf(2), 32'd18);

        smp = pack3(val[0], val[1], 16'h5555);
        applyStimulus(smp, 1'b0);
        for (int c = 0; c < NCH; c++) val[c] = val[c] + 16'd1;
        cycleRamp(1, 1'b1);
        check("clr_wins_main", err_cnt, '0);
        check("clr_wins_sat", err_cnt_s, '0);
        cycleRamp(2, 1'b0);

        #2 rst_n = 1'b0;
        #1;
        check("areset_locked", locked, '0);
        check("areset_err", err_cnt, '0);
        check("areset_dout", dout, '0);
        check("areset_vld", dout_vld, 1'b0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        runLockTable();
        cycleRamp(4, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
